hash_word_sequencer: RTL and testbench
======================================

Name: hash_word_sequencer

Overview:
- Controller for the 256-bit hash display path: latches a hash, drives the 4-bit word select into the 16:1 word mux, and time-multiplexes the selected 16-bit word onto four seven-segment digit positions.
- Supports auto-advance through the 16 words, manual stepping, and a ready/valid handshake for loading new hashes.
- Sits between the hash generator and the seven-segment decoders.

Parameters:
- STEP_TICKS, 50_000_000, clk cycles per word advance in AUTO (>=2)
- SCAN_TICKS, 50_000, clk cycles per digit refresh slot (>=2)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- hash_in  in  256  hash to display
- hash_valid  in  1  hash_in valid; accepted when hash_valid & hash_ready
- hash_ready  out  1  block can accept a hash this cycle
- run  in  1  level; 1 = auto-advance words
- step  in  1  single-cycle pulse; advance one word while paused
- clear  in  1  single-cycle pulse; discard hash, return to EMPTY
- hashed  out  256  latched hash, feeds the word mux data input
- sel  out  4  word index, feeds the word mux select
- word_in  in  16  selected word returned from the mux (combinational from hashed/sel)
- digit_val  out  4  nibble for the currently enabled digit
- digit_en  out  4  one-hot, active-high digit enable; bit i selects word nibble i
- wrap  out  1  one-cycle pulse when sel advances 15 -> 0
- state_o  out  2  00 EMPTY, 01 SHOW, 10 AUTO

Behaviour:
- Reset (async):
  - state = EMPTY; hashed, sel, digit_val, digit_en and wrap all = 0.
  - Step counter and scan counter = 0; digit index = 0.
- hash_ready (combinational):
  - EMPTY or SHOW: 1.
  - AUTO: 1 only while sel == 15.
- Accept (hash_valid & hash_ready, not clear):
  - hashed <= hash_in; sel <= 0; step counter <= 0.
  - Next state is AUTO if run = 1, else SHOW.
- EMPTY:
  - digit_en = 0000, digit_val = 0.
  - Scan counter held at 0; step and run ignored.
- SHOW:
  - step pulse: sel <= sel + 1 mod 16; wrap = 1 on the 15 -> 0 transition.
  - run = 1 (no accept, no clear): go to AUTO with step counter = 0.
- AUTO:
  - Step counter counts 0..STEP_TICKS-1. At terminal count with run = 1, it returns to 0 and sel <= sel + 1 mod 16 (wrap on 15 -> 0).
  - run = 0: go to SHOW next cycle, sel held, no advance that cycle, step counter <= 0.
  - step ignored.
- clear:
  - From any state: state <= EMPTY; hashed, sel, counters, digit_en and digit_val <= 0.
- Digit scan (SHOW/AUTO only):
  - Scan counter counts 0..SCAN_TICKS-1; at terminal count, digit index <= index + 1 mod 4.
  - Every cycle (registered, 1-cycle latency): digit_en <= one-hot(index); digit_val <= word_in[4*index+3 : 4*index].
  - First entry from EMPTY starts at index 0, so digit_en = 0001 one cycle after acceptance.
- Simultaneous-event priority: clear > accept > step/auto advance > run-driven state change.
  - Accept coinciding with an auto terminal count or a step: sel = 0, no wrap pulse.
- wrap is registered, exactly one cycle high per wrap, 0 otherwise.
- Width rules: sel wraps naturally in 4 bits; counters sized by $clog2 of each parameter; no overflow beyond terminal count.

Test Plan:
Bench parameters: STEP_TICKS = 4, SCAN_TICKS = 2.
- Reset mid-AUTO (sel = 7): assert reset asynchronously. Immediately: state_o = 00, sel = 0, hashed = 0, digit_en = 0000, hash_ready = 1.
- Load hash_in = {16'hFFFF, ..., 16'h0001, 16'h0000} (word k = k, word 15 = FFFF) with run = 0:
  - state_o = 01, sel = 0.
  - After 1 cycle: digit_en = 0001, digit_val = 0.
  - Digit index advances every 2 cycles: digit_en 0001 -> 0010 -> 0100 -> 1000 -> 0001.
- In SHOW, issue 16 step pulses from sel = 0: sel visits 1..15, then 0; wrap pulses once, on the 15 -> 0 step; hash_ready stays 1 throughout.
- run = 1 from sel = 0:
  - sel increments every 4 cycles.
  - hash_ready = 0 while sel = 0..14, and 1 while sel = 15.
  - A hash_valid offered at sel = 3 is not accepted; hashed is unchanged.
- In AUTO at sel = 15, offer a new hash in the same cycle as the step terminal count: new hash latched, sel = 0, wrap = 0. Then drop run: state_o = 01 next cycle and sel holds.
- clear and hash_valid in the same cycle while in SHOW: state_o = 00, hashed = 0, digit_en = 0000, and the offered hash is discarded.

Source files
------------

// File: rtl/hash_word_sequencer.sv
// Hash display controller: latches a 256-bit hash, walks the 16:1 word select
// (manual or timed), and scans the selected word across four digit positions.
module hash_word_sequencer #(
    parameter int STEP_TICKS = 50_000_000,
    parameter int SCAN_TICKS = 50_000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [255:0] hash_in,
    input  logic         hash_valid,
    output logic         hash_ready,
    input  logic         run,
    input  logic         step,
    input  logic         clear,
    output logic [255:0] hashed,
    output logic [3:0]   sel,
    input  logic [15:0]  word_in,
    output logic [3:0]   digit_val,
    output logic [3:0]   digit_en,
    output logic         wrap,
    output logic [1:0]   state_o
);

    localparam int STEP_W = $clog2(STEP_TICKS);
    localparam int SCAN_W = $clog2(SCAN_TICKS);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_TICKS - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_TICKS - 1);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        SHOW  = 2'b01,
        AUTO  = 2'b10
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [STEP_W-1:0] step_cnt;
    logic [SCAN_W-1:0] scan_cnt;
    logic [1:0]        digit_idx;
    logic              accept;
    logic              advance;
    logic              step_count_on;
    logic              step_term;
    logic              scan_term;

    function automatic logic [3:0] one_hot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    assign state_o   = state;
    assign step_term = (step_cnt == STEP_LAST);
    assign scan_term = (scan_cnt == SCAN_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Priority: clear, then accept, then advance, then run-driven transitions.
    always_comb begin
        state_next    = state;
        advance       = 1'b0;
        step_count_on = 1'b0;
        hash_ready    = (state == AUTO) ? (sel == 4'hF) : 1'b1;
        accept        = hash_valid && hash_ready && !clear;
        if (clear) begin
            state_next = EMPTY;
        end else if (accept) begin
            state_next = run ? AUTO : SHOW;
        end else begin
            case (state)
                EMPTY: state_next = EMPTY;
                SHOW: begin
                    advance = step;
                    if (run) begin
                        state_next = AUTO;
                    end
                end
                AUTO: begin
                    if (!run) begin
                        state_next = SHOW;
                    end else if (step_term) begin
                        advance = 1'b1;
                    end else begin
                        step_count_on = 1'b1;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hashed   <= '0;
            sel      <= '0;
            wrap     <= 1'b0;
            step_cnt <= '0;
        end else begin
            wrap     <= 1'b0;
            step_cnt <= step_count_on ? step_cnt + 1'b1 : '0;
            if (clear) begin
                hashed <= '0;
                sel    <= '0;
            end else if (accept) begin
                hashed <= hash_in;
                sel    <= '0;
            end else if (advance) begin
                sel  <= sel + 4'd1;
                wrap <= (sel == 4'hF);
            end
        end
    end

    // Digit scan stage: outputs are registered from the index and word seen this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
            digit_en  <= '0;
            digit_val <= '0;
        end else if (clear || state == EMPTY) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
            digit_en  <= '0;
            digit_val <= '0;
        end else begin
            digit_en  <= one_hot4(digit_idx);
            digit_val <= word_in[{digit_idx, 2'b00} +: 4];
            if (scan_term) begin
                scan_cnt  <= '0;
                digit_idx <= digit_idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hash_word_sequencer.sv
// Randomised plus directed bench for hash_word_sequencer with a queue-based scoreboard.
module tb_hash_word_sequencer;

    localparam int STEP = 4;
    localparam int SCAN = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] hash_in;
    logic         hash_valid;
    logic         hash_ready;
    logic         run;
    logic         step;
    logic         clear;
    logic [255:0] hashed;
    logic [3:0]   sel;
    logic [15:0]  word_in;
    logic [3:0]   digit_val;
    logic [3:0]   digit_en;
    logic         wrap;
    logic [1:0]   state_o;

    hash_word_sequencer #(.STEP_TICKS(STEP), .SCAN_TICKS(SCAN)) dut (
        .clk(clk), .reset(reset), .hash_in(hash_in), .hash_valid(hash_valid),
        .hash_ready(hash_ready), .run(run), .step(step), .clear(clear),
        .hashed(hashed), .sel(sel), .word_in(word_in), .digit_val(digit_val),
        .digit_en(digit_en), .wrap(wrap), .state_o(state_o)
    );

    // Stand-in for the external 16:1 word mux.
    assign word_in = hashed[{sel, 4'b0000} +: 16];

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   st;
        logic [3:0]   sel;
        logic [255:0] hsh;
        logic         wrap;
        logic [3:0]   en;
        logic [3:0]   val;
        logic         rdy;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // Reference model: 0 EMPTY, 1 SHOW, 2 AUTO; tick counts cycles spent in AUTO.
    int           m_state, m_sel, m_tick, m_scan, m_idx;
    logic [255:0] m_hash;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_sel = 0; m_tick = 0; m_scan = 0; m_idx = 0; m_hash = '0;
    endtask

    task automatic model(input logic v, input logic r, input logic s, input logic c,
                         input logic [255:0] h, output exp_t e);
        logic         rdy, acc;
        logic [255:0] sh;
        int           ns, nsel, ntick;
        rdy = (m_state == 2) ? (m_sel == 15) : 1'b1;
        acc = v && rdy && !c;
        e.wrap = 1'b0;
        if (c || m_state == 0) begin
            e.en = 4'd0; e.val = 4'd0; m_scan = 0; m_idx = 0;
        end else begin
            e.en  = 4'(1 << m_idx);
            sh    = m_hash >> (16 * m_sel + 4 * m_idx);
            e.val = sh[3:0];
            if (m_scan == SCAN - 1) begin
                m_scan = 0; m_idx = (m_idx + 1) % 4;
            end else begin
                m_scan++;
            end
        end
        ns = m_state; nsel = m_sel; ntick = 0;
        if (c) begin
            ns = 0; nsel = 0; m_hash = '0;
        end else if (acc) begin
            m_hash = h; nsel = 0; ns = r ? 2 : 1;
        end else if (m_state == 1) begin
            if (s) begin
                nsel = (m_sel + 1) % 16; e.wrap = (m_sel == 15);
            end
            if (r) ns = 2;
        end else if (m_state == 2) begin
            if (!r) ns = 1;
            else if (m_tick == STEP - 1) begin
                nsel = (m_sel + 1) % 16; e.wrap = (m_sel == 15);
            end else ntick = m_tick + 1;
        end
        m_state = ns; m_sel = nsel; m_tick = ntick;
        e.st  = 2'(m_state);
        e.sel = 4'(m_sel);
        e.hsh = m_hash;
        e.rdy = (m_state == 2) ? (m_sel == 15) : 1'b1;
    endtask

    task automatic cycle(input logic v, input logic r, input logic s, input logic c,
                         input logic [255:0] h);
        exp_t e;
        hash_valid = v; run = r; step = s; clear = c; hash_in = h;
        model(v, r, s, c, h, e);
        @(posedge clk);
        sb.push_back(e);
        #1;
        hash_valid = 1'b0; step = 1'b0; clear = 1'b0;
    endtask

    function automatic logic [255:0] rand_hash();
        logic [255:0] x;
        for (int i = 0; i < 8; i++) x[32*i +: 32] = $urandom;
        return x;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("state_o", 256'(state_o), 256'(e.st));
            check("sel", 256'(sel), 256'(e.sel));
            check("hashed", hashed, e.hsh);
            check("wrap", 256'(wrap), 256'(e.wrap));
            check("digit_en", 256'(digit_en), 256'(e.en));
            check("digit_val", 256'(digit_val), 256'(e.val));
            check("hash_ready", 256'(hash_ready), 256'(e.rdy));
        end
    end

    initial begin
        logic [255:0] pat;
        int budget;
        reset = 1'b1; hash_in = '0; hash_valid = 0; run = 0; step = 0; clear = 0;
        model_reset();
        #23;
        check("rst_state", 256'(state_o), 256'd0);
        check("rst_en", 256'(digit_en), 256'd0);
        check("rst_ready", 256'(hash_ready), 256'd1);
        reset = 1'b0;

        // Auto-run to sel 7, then reset asynchronously mid-cycle.
        cycle(1, 1, 0, 0, rand_hash());
        budget = 0;
        while (!(m_state == 2 && m_sel == 7) && budget < 200) begin
            cycle(0, 1, 0, 0, '0); budget++;
        end
        if (budget >= 200) begin
            errors++; checks++;
            $display("FAIL reach_sel7: model sel %0d never reached 7", m_sel);
        end
        check("pre_rst_sel", 256'(sel), 256'd7);
        #6;
        reset = 1'b1; run = 1'b0;
        #1;
        check("async_state", 256'(state_o), 256'd0);
        check("async_sel", 256'(sel), 256'd0);
        check("async_hashed", hashed, 256'd0);
        check("async_en", 256'(digit_en), 256'd0);
        check("async_ready", 256'(hash_ready), 256'd1);
        @(posedge clk); @(posedge clk); #3;
        reset = 1'b0;
        model_reset();

        // Patterned hash: word k holds k, word 15 holds FFFF.
        for (int k = 0; k < 16; k++) pat[16*k +: 16] = 16'(k);
        pat[255:240] = 16'hFFFF;
        cycle(1, 0, 0, 0, pat);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, '0);

        // Sixteen manual steps.
        for (int i = 0; i < 16; i++) begin
            cycle(0, 0, 1, 0, '0);
            cycle(0, 0, 0, 0, '0);
        end
        check("steps_sel", 256'(sel), 256'd0);

        // Auto-advance; offer a hash at sel 3, then accept one at sel 15 terminal.
        budget = 0;
        while (!(m_state == 2 && m_sel == 15 && m_tick == STEP - 1) && budget < 200) begin
            cycle((m_state == 2 && m_sel == 3), 1, 0, 0, rand_hash()); budget++;
        end
        if (budget >= 200) begin
            errors++; checks++;
            $display("FAIL reach_term15: model never reached sel 15 terminal");
        end
        pat = rand_hash();
        cycle(1, 1, 0, 0, pat);
        check("late_accept", hashed, pat);
        cycle(0, 1, 0, 0, '0);
        cycle(0, 0, 0, 0, '0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, '0);

        // clear beats a simultaneous hash offer in SHOW.
        cycle(1, 0, 0, 1, rand_hash());
        check("clear_hashed", hashed, 256'd0);
        cycle(0, 0, 0, 0, '0);

        // Random traffic.
        run = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic r;
            r = run;
            if ($urandom_range(0, 15) == 0) r = ~r;
            cycle($urandom_range(0, 7) == 0, r, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 63) == 0, rand_hash());
        end

        @(posedge clk); @(posedge clk);
        if (sb.size() != 0) begin
            errors++; checks++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
